chf_rom_loader: RTL and testbench

- Receiving end of the hps_io ioctl download stream inside chf_core.
- Accepts cartridge bytes for the "FS,ROMBIN" menu entry and writes them through a request/acknowledge port into cartridge ROM storage.
- Throttles the HPS with io_ioctl_wait while a write is pending.
- After the download, publishes the image size and a power-of-two mirror mask for the cartridge address decoder, and holds the console in reset while loading.

---
 rtl/chf_pkg.sv | 14 +
 rtl/chf_size_to_mask.sv | 27 ++
 rtl/chf_rom_loader.sv | 138 +++++++++++++
 tb/tb_chf_rom_loader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chf_pkg.sv
// Shared types and constants for the cartridge ROM download path.
package chf_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      WRITE,
      FINISH
   } loader_state_t;

   localparam int unsigned CHF_ROM_INDEX  = 1;
   localparam int unsigned CHF_ROM_ADDR_W = 16;

endpackage

// File: rtl/chf_size_to_mask.sv
// Mirror mask for the cartridge decoder: all ones at and below the MSB of (size-1).
module chf_size_to_mask
   import chf_pkg::*;
#(
   parameter int unsigned ADDR_W = CHF_ROM_ADDR_W
) (
   input  logic [ADDR_W:0]   size,
   output logic [ADDR_W-1:0] mask
);

   logic [ADDR_W-1:0] diff;
   logic [ADDR_W-1:0] smear;
   logic              seen;

   // Low bits of size minus one: size=2^ADDR_W wraps to all ones, which is the wanted mask.
   always_comb begin
      diff  = size[ADDR_W-1:0] - ADDR_W'(1);
      smear = '0;
      seen  = 1'b0;
      for (int unsigned j = 0; j < ADDR_W; j++) begin
         seen                 = seen | diff[ADDR_W-1-j];
         smear[ADDR_W-1-j]    = seen;
      end
      mask = (size == '0) ? '0 : smear;
   end

endmodule

// File: rtl/chf_rom_loader.sv
// Receives the ioctl cartridge download and writes it into ROM storage via req/ack.
module chf_rom_loader
   import chf_pkg::*;
#(
   parameter int unsigned ADDR_W    = CHF_ROM_ADDR_W,
   parameter int unsigned ROM_INDEX = CHF_ROM_INDEX
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              io_ioctl_download,
   input  logic [7:0]        io_ioctl_index,
   input  logic              io_ioctl_wr,
   input  logic [24:0]       io_ioctl_addr,
   input  logic [7:0]        io_ioctl_dout,
   output logic              io_ioctl_wait,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic              mem_ack,
   output logic              core_hold,
   output logic              rom_valid,
   output logic [ADDR_W:0]   rom_size,
   output logic [ADDR_W-1:0] rom_mask,
   output logic              overflow
);

   loader_state_t     state_q, state_d;
   logic              wait_q, wait_d;
   logic              req_q, req_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              hold_q, hold_d;
   logic              valid_q, valid_d;
   logic [ADDR_W:0]   size_q, size_d;
   logic [ADDR_W-1:0] mask_q, mask_d;
   logic              ovf_q, ovf_d;

   logic              in_range;
   logic [ADDR_W:0]   wr_end;
   logic [ADDR_W-1:0] mask_w;

   chf_size_to_mask #(.ADDR_W(ADDR_W)) u_mask (
      .size (size_q),
      .mask (mask_w)
   );

   assign in_range = (io_ioctl_addr >> ADDR_W) == '0;
   assign wr_end   = {1'b0, addr_q} + (ADDR_W+1)'(1);

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      req_d   = req_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      hold_d  = hold_q;
      valid_d = valid_q;
      size_d  = size_q;
      mask_d  = mask_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (io_ioctl_download && io_ioctl_index == 8'(ROM_INDEX)) begin
               state_d = LOAD;
               hold_d  = 1'b1;
               valid_d = 1'b0;
               size_d  = '0;
               ovf_d   = 1'b0;
            end
         end
         LOAD: begin
            // A strobe coinciding with the end of download is still taken.
            if (io_ioctl_wr && in_range) begin
               addr_d  = io_ioctl_addr[ADDR_W-1:0];
               wdata_d = io_ioctl_dout;
               req_d   = 1'b1;
               wait_d  = 1'b1;
               state_d = WRITE;
            end else begin
               if (io_ioctl_wr) ovf_d = 1'b1;
               if (!io_ioctl_download) state_d = FINISH;
            end
         end
         WRITE: begin
            if (mem_ack) begin
               req_d   = 1'b0;
               wait_d  = 1'b0;
               if (wr_end > size_q) size_d = wr_end;
               state_d = io_ioctl_download ? LOAD : FINISH;
            end
         end
         FINISH: begin
            mask_d  = mask_w;
            valid_d = (size_q != '0);
            hold_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         wait_q  <= 1'b0;
         req_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         hold_q  <= 1'b0;
         valid_q <= 1'b0;
         size_q  <= '0;
         mask_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         hold_q  <= hold_d;
         valid_q <= valid_d;
         size_q  <= size_d;
         mask_q  <= mask_d;
         ovf_q   <= ovf_d;
      end
   end

   assign io_ioctl_wait = wait_q;
   assign mem_req       = req_q;
   assign mem_addr      = addr_q;
   assign mem_wdata     = wdata_q;
   assign core_hold     = hold_q;
   assign rom_valid     = valid_q;
   assign rom_size      = size_q;
   assign rom_mask      = mask_q;
   assign overflow      = ovf_q;

endmodule

// File: tb/tb_chf_rom_loader.sv
// Scoreboard bench for chf_rom_loader: expected writes queued by the driver, checked by a monitor.
module tb_chf_rom_loader;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned CAP    = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              reset;
   logic              io_ioctl_download;
   logic [7:0]        io_ioctl_index;
   logic              io_ioctl_wr;
   logic [24:0]       io_ioctl_addr;
   logic [7:0]        io_ioctl_dout;
   logic              io_ioctl_wait;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              mem_ack;
   logic              core_hold;
   logic              rom_valid;
   logic [ADDR_W:0]   rom_size;
   logic [ADDR_W-1:0] rom_mask;
   logic              overflow;

   chf_rom_loader #(.ADDR_W(ADDR_W), .ROM_INDEX(1)) dut (
      .clk               (clk),
      .reset             (reset),
      .io_ioctl_download (io_ioctl_download),
      .io_ioctl_index    (io_ioctl_index),
      .io_ioctl_wr       (io_ioctl_wr),
      .io_ioctl_addr     (io_ioctl_addr),
      .io_ioctl_dout     (io_ioctl_dout),
      .io_ioctl_wait     (io_ioctl_wait),
      .mem_req           (mem_req),
      .mem_addr          (mem_addr),
      .mem_wdata         (mem_wdata),
      .mem_ack           (mem_ack),
      .core_hold         (core_hold),
      .rom_valid         (rom_valid),
      .rom_size          (rom_size),
      .rom_mask          (rom_mask),
      .overflow          (overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [ADDR_W+7:0] sb[$];
   int unsigned exp_size;
   bit          exp_ovf;

   bit ack_tied = 0;
   bit ack_off  = 0;
   int ack_delay = 1;
   int ack_cnt   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Storage-side responder.
   initial begin
      mem_ack = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (ack_tied) mem_ack = 1'b1;
         else begin
            mem_ack = 1'b0;
            if (mem_req && !ack_off) begin
               if (ack_cnt >= ack_delay) begin
                  mem_ack = 1'b1;
                  ack_cnt = 0;
               end else ack_cnt++;
            end else ack_cnt = 0;
         end
      end
   end

   // Monitor: every accepted write must match the oldest expected byte.
   initial begin
      logic [ADDR_W+7:0] e;
      forever begin
         @(negedge clk);
         if (!reset && mem_req) begin
            chk("wait_tracks_req", io_ioctl_wait, 1);
            if (mem_ack) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", mem_addr, mem_wdata);
               end else begin
                  e = sb.pop_front();
                  chk("wr_addr", 32'(mem_addr), 32'(e[ADDR_W+7:8]));
                  chk("wr_data", 32'(mem_wdata), 32'(e[7:0]));
               end
            end
         end
      end
   end

   function automatic int unsigned model_mask(input int unsigned size);
      int unsigned m = 0;
      if (size == 0) return 0;
      while (m < size - 1) m = m * 2 + 1;
      return m;
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic start_dl(input logic [7:0] idx);
      io_ioctl_download = 1'b1;
      io_ioctl_index    = idx;
      tick();
      if (idx == 8'd1) begin
         exp_size = 0;
         exp_ovf  = 0;
         chk("hold_in_load", core_hold, 1);
         chk("valid_cleared", rom_valid, 0);
      end
   endtask

   task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit end_dl);
      int n = 0;
      bit ok;
      while (io_ioctl_wait && n < 50) begin
         tick();
         n++;
      end
      if (io_ioctl_wait) chk("stall_timeout", io_ioctl_wait, 0);
      ok = (a < 25'(CAP));
      if (ok) begin
         sb.push_back({a[ADDR_W-1:0], d});
         if (a + 1 > exp_size) exp_size = a + 1;
      end else exp_ovf = 1;
      io_ioctl_wr   = 1'b1;
      io_ioctl_addr = a;
      io_ioctl_dout = d;
      if (end_dl) io_ioctl_download = 1'b0;
      tick();
      io_ioctl_wr = 1'b0;
      chk("wait_after_strobe", io_ioctl_wait, 32'(ok));
   endtask

   task automatic finish_check();
      int n = 0;
      io_ioctl_download = 1'b0;
      while (core_hold && n < 50) begin
         tick();
         n++;
      end
      chk("hold_release", core_hold, 0);
      chk("rom_valid", rom_valid, 32'(exp_size != 0));
      chk("rom_size", 32'(rom_size), exp_size);
      chk("rom_mask", 32'(rom_mask), model_mask(exp_size));
      chk("overflow", overflow, 32'(exp_ovf));
      chk("queue_drained", sb.size(), 0);
   endtask

   initial begin
      int first_cyc, last_cyc;
      logic [7:0] pat[4];
      reset = 1'b1;
      io_ioctl_download = 0; io_ioctl_index = 0; io_ioctl_wr = 0;
      io_ioctl_addr = 0; io_ioctl_dout = 0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      chk("rst_wait", io_ioctl_wait, 0);
      chk("rst_req", mem_req, 0);
      chk("rst_hold", core_hold, 0);
      chk("rst_valid", rom_valid, 0);
      chk("rst_size", 32'(rom_size), 0);
      chk("rst_mask", 32'(rom_mask), 0);
      chk("rst_ovf", overflow, 0);

      // Four bytes, ack one cycle after each request.
      pat[0] = 8'hAA; pat[1] = 8'h55; pat[2] = 8'h01; pat[3] = 8'hFF;
      ack_delay = 1;
      start_dl(8'd1);
      for (int i = 0; i < 4; i++) send_byte(25'(i), pat[i], 0);
      finish_check();

      // Index 0 is ignored entirely.
      start_dl(8'd0);
      for (int i = 0; i < 16; i++) begin
         io_ioctl_wr = 1'b1; io_ioctl_addr = 25'(i); io_ioctl_dout = 8'($urandom);
         tick();
         io_ioctl_wr = 1'b0;
         tick();
         if (core_hold || mem_req) chk("idx0_quiet", {core_hold, mem_req}, 0);
      end
      io_ioctl_download = 1'b0;
      repeat (3) tick();
      chk("idx0_size", 32'(rom_size), 4);
      chk("idx0_mask", 32'(rom_mask), 3);
      chk("idx0_valid", rom_valid, 1);
      chk("idx0_hold", core_hold, 0);

      // 4097 bytes, ack tied high: 2 cycles per byte.
      ack_tied = 1;
      start_dl(8'd1);
      first_cyc = 0; last_cyc = 0;
      for (int i = 0; i < 4097; i++) begin
         send_byte(25'(i), 8'($urandom), 0);
         if (i == 0) first_cyc = cyc;
         last_cyc = cyc;
      end
      chk("two_cycles_per_byte", 32'(last_cyc - first_cyc), 2 * 4096);
      finish_check();
      ack_tied = 0;

      // Out-of-range byte dropped, then in-range byte.
      start_dl(8'd1);
      send_byte(25'h10000, 8'h3C, 0);
      chk("ovf_sticky", overflow, 1);
      send_byte(25'h00005, 8'hC3, 0);
      finish_check();

      // Download ends with the last strobe; slow ack.
      ack_delay = 5;
      start_dl(8'd1);
      send_byte(25'h10, 8'h11, 0);
      send_byte(25'h2, 8'h22, 1);
      finish_check();

      // Zero-byte download.
      start_dl(8'd1);
      repeat (9) tick();
      finish_check();

      // Randomised downloads with random ack latency and occasional overflow.
      for (int r = 0; r < 4; r++) begin
         ack_delay = $urandom_range(0, 3);
         start_dl(8'd1);
         for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0)
               send_byte(25'(CAP + $urandom_range(0, 5000)), 8'($urandom), 0);
            else
               send_byte(25'($urandom_range(0, 1023)), 8'($urandom), 0);
         end
         finish_check();
      end

      // Reset while a write is outstanding and never acknowledged.
      ack_off = 1;
      start_dl(8'd1);
      send_byte(25'h7, 8'h77, 0);
      tick();
      chk("req_pending", mem_req, 1);
      reset = 1'b1;
      io_ioctl_download = 1'b0;
      tick();
      sb.delete();
      chk("mid_rst_wait", io_ioctl_wait, 0);
      chk("mid_rst_req", mem_req, 0);
      chk("mid_rst_addr", 32'(mem_addr), 0);
      chk("mid_rst_data", 32'(mem_wdata), 0);
      chk("mid_rst_hold", core_hold, 0);
      chk("mid_rst_valid", rom_valid, 0);
      chk("mid_rst_size", 32'(rom_size), 0);
      chk("mid_rst_ovf", overflow, 0);
      reset = 1'b0;
      ack_off = 0;
      ack_delay = 0;
      tick();
      start_dl(8'd1);
      send_byte(25'h0, 8'h5A, 0);
      send_byte(25'h1, 8'hA5, 0);
      finish_check();

      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
